neighbor_link_ctx_v3: RTL
=========================

Name: neighbor_link_ctx_v3

Overview:
- Generalised multi-context edge between two processing elements A and B in the decoder fabric.
- Tracks saturating growth and error state for the live context, and forwards exposed data between A and B.
- Saves and restores per-context state through a request/ready context-switch handshake, replacing the fixed ring-order write-to-memory scheme.
- Holds per-context weight and boundary configuration locally, and provides a bulk clear of all contexts.

Parameters:
- ADDRESS_WIDTH, 6, PE address width; exposed data width EXP_W = ADDRESS_WIDTH+3.
- MAX_WEIGHT, 2, largest edge weight; LINK_BIT_WIDTH = $clog2(MAX_WEIGHT+1).
- NUM_CONTEXTS, 4, number of stored contexts, any value ≥2; CTX_W = max(1,$clog2(NUM_CONTEXTS)).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- global_stage  in  STAGE_WIDTH  decoder stage
- a_increase, b_increase  in  1  growth request from each side
- a_is_error_in, b_is_error_in  in  1  peeling error marks
- is_error_systolic_in  in  1  result-shift input
- a_input_data, b_input_data  in  EXP_W  exposed data from A/B
- a_output_data, b_output_data  out  EXP_W  forwarded data
- fully_grown  out  1  growth ≥ weight on a real edge
- is_boundary  out  1  fully grown boundary or fusion edge
- is_error  out  1  live error flag
- reset_edge  in  1  clear live growth
- cfg_we  in  1  config write strobe
- cfg_ctx  in  CTX_W  config target context
- weight_in  in  LINK_BIT_WIDTH  config weight
- boundary_condition_in  in  2  0 none, 1 boundary, 2 absent, 3 fusion
- ctx_switch_valid  in  1  switch request
- ctx_next  in  CTX_W  context to load
- ctx_switch_ready  out  1  FSM idle, can accept a switch
- ctx_clear_all  in  1  zero every stored context
- ctx_current  out  CTX_W  live context index

Behaviour:
- Reset: asynchronous, active-high. Clock is clk, reset is reset.
  - Zeroes growth, is_error, ctx_current and all config registers.
  - FSM enters CLEAR, so ctx_switch_ready=0.
- Config:
  - Array cfg[NUM_CONTEXTS] of {weight, bc}, written when cfg_we is high, in any FSM state.
  - Live weight and bc are cfg[ctx_current], read combinationally. A write to the current context takes effect the next cycle.
- State RAM:
  - Single-port synchronous RAM, depth NUM_CONTEXTS, width LINK_BIT_WIDTH+1, holding {growth, is_error}.
  - No reset on the RAM itself.
- Growth (FSM IDLE only; frozen otherwise):
  - bc 0 or 3: g' = growth + a_increase + b_increase.
  - bc 1: g' = growth + a_increase.
  - bc 2: g' = 0.
  - Sum computed at $clog2(MAX_WEIGHT+3) bits and saturated at weight.
  - reset_edge forces growth=0 and has priority over growth.
- is_error (IDLE only):
  - bc 2: 0.
  - stage==STAGE_RESULT_VALID: is_error_systolic_in.
  - Otherwise bc 1: a_is_error_in; bc 0 or 3: a_is_error_in | b_is_error_in.
- fully_grown = (growth ≥ weight) && bc≠2.
- is_boundary = fully_grown && (bc==1 || bc==3).
- a_output_data = (bc==0) ? b_input_data : 0. b_output_data mirrors this.
- FSM states: CLEAR, IDLE, SAVE, LOAD.
  - ctx_switch_ready = (state==IDLE).
  - IDLE:
    - ctx_clear_all → CLEAR. Takes priority over a same-cycle valid, which is not accepted.
    - valid && ready → SAVE; latch ctx_next.
  - SAVE (1 cycle): write {growth, is_error} to RAM[ctx_current] → LOAD.
  - LOAD (1 cycle): read RAM[latched next] → IDLE. Growth and is_error take the RAM output in the first IDLE cycle, and ctx_current updates in that same cycle.
  - Switch latency: accepted at cycle T; new state is live and ready=1 at T+3. ctx_next==ctx_current is legal and restores the saved value.
  - CLEAR: write zeros to addresses 0..NUM_CONTEXTS-1, one per cycle. Then zero live growth and is_error, set ctx_current=0, → IDLE. Lasts NUM_CONTEXTS cycles. Config is untouched.
- Reset asserted in any state aborts it and restarts CLEAR.
- ctx_next ≥ NUM_CONTEXTS is a protocol violation; an assertion flags it.

Decomposition:
- Shared package holds:
  - Stage constants, including STAGE_RESULT_VALID.
  - Boundary-condition encodings BC_NONE, BC_BOUNDARY, BC_ABSENT, BC_FUSION.
  - FSM state enum ctx_fsm_t.
- One sub-module: link_ctx_ram, a parametrised single-port sync RAM with write enable.

Test Plan:
- Reset release → ready=0 for 4 cycles, then 1; ctx_current=0, growth=0.
- cfg ctx0 weight=2, bc=0; a_increase=b_increase=1 for one cycle → growth=2 and fully_grown=1 next cycle. Three more cycles leave growth saturated at 2.
- Two contexts:
  - ctx0 grown to 1 with is_error=1; switch to ctx2 → ready low for T+1..T+2; at T+3 growth=0, ctx_current=2.
  - Switch back to ctx0 → growth=1, is_error=1.
- bc=1, b_increase=1 only → growth unchanged. Then weight=1 and a_increase=1 → is_boundary=1.
- ctx_clear_all issued together with ctx_switch_valid → switch not accepted; after 4 cycles all contexts read back as zero.
- Reset asserted during SAVE → outputs zero immediately; the full CLEAR sequence reruns.

Source files
------------

// File: rtl/neighbor_link_ctx_v3_pkg.sv
// Shared constants and types for the multi-context neighbor link.
// Stage encodings, boundary-condition codes and the context FSM states.
package neighbor_link_ctx_v3_pkg;

    localparam int STAGE_WIDTH = 3;

    localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                  = 3'd0;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_PREPARING = 3'd1;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING   = 3'd2;
    localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                  = 3'd3;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE                 = 3'd4;
    localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING               = 3'd5;
    localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID          = 3'd6;

    localparam logic [1:0] BC_NONE     = 2'd0;
    localparam logic [1:0] BC_BOUNDARY = 2'd1;
    localparam logic [1:0] BC_ABSENT   = 2'd2;
    localparam logic [1:0] BC_FUSION   = 2'd3;

    typedef enum logic [1:0] {
        CTX_CLEAR = 2'd0,
        CTX_IDLE  = 2'd1,
        CTX_SAVE  = 2'd2,
        CTX_LOAD  = 2'd3
    } ctx_fsm_t;

endpackage

// File: rtl/neighbor_link_ctx_v3_ram.sv
// Single-port synchronous RAM holding saved {growth, is_error} per context.
// Read data is registered every cycle; no reset on the storage.
module link_ctx_ram #(
    parameter int DEPTH  = 4,
    parameter int WIDTH  = 3,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/neighbor_link_ctx_v3.sv
// Multi-context edge between PEs A and B: saturating growth, error tracking,
// data forwarding and save/restore of per-context state via a switch handshake.
module neighbor_link_ctx_v3
    import neighbor_link_ctx_v3_pkg::*;
#(
    parameter int  ADDRESS_WIDTH  = 6,
    parameter int  MAX_WEIGHT     = 2,
    parameter int  NUM_CONTEXTS   = 4,
    localparam int EXP_W          = ADDRESS_WIDTH + 3,
    localparam int LINK_BIT_WIDTH = $clog2(MAX_WEIGHT + 1),
    localparam int CTX_W          = (NUM_CONTEXTS > 2) ? $clog2(NUM_CONTEXTS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [STAGE_WIDTH-1:0]    global_stage,
    input  logic                      a_increase,
    input  logic                      b_increase,
    input  logic                      a_is_error_in,
    input  logic                      b_is_error_in,
    input  logic                      is_error_systolic_in,
    input  logic [EXP_W-1:0]          a_input_data,
    input  logic [EXP_W-1:0]          b_input_data,
    output logic [EXP_W-1:0]          a_output_data,
    output logic [EXP_W-1:0]          b_output_data,
    output logic                      fully_grown,
    output logic                      is_boundary,
    output logic                      is_error,
    input  logic                      reset_edge,
    input  logic                      cfg_we,
    input  logic [CTX_W-1:0]          cfg_ctx,
    input  logic [LINK_BIT_WIDTH-1:0] weight_in,
    input  logic [1:0]                boundary_condition_in,
    input  logic                      ctx_switch_valid,
    input  logic [CTX_W-1:0]          ctx_next,
    output logic                      ctx_switch_ready,
    input  logic                      ctx_clear_all,
    output logic [CTX_W-1:0]          ctx_current
);

    localparam int SUM_W = $clog2(MAX_WEIGHT + 3);
    localparam int RAM_W = LINK_BIT_WIDTH + 1;

    ctx_fsm_t                  state_q, state_d;
    logic [LINK_BIT_WIDTH-1:0] growth_q, growth_d, growth_live, grown;
    logic                      error_q, error_d, error_live, error_next;
    logic [CTX_W-1:0]          ctx_cur_q, ctx_cur_d, ctx_next_q, clear_idx_q;
    logic                      first_idle_q;
    logic [SUM_W-1:0]          sum;

    logic [LINK_BIT_WIDTH-1:0] cfg_weight_q [NUM_CONTEXTS];
    logic [1:0]                cfg_bc_q     [NUM_CONTEXTS];
    logic [LINK_BIT_WIDTH-1:0] weight;
    logic [1:0]                bc;

    logic                      ram_we;
    logic [CTX_W-1:0]          ram_addr;
    logic [RAM_W-1:0]          ram_wdata, ram_rdata;

    assign weight = cfg_weight_q[ctx_cur_q];
    assign bc     = cfg_bc_q[ctx_cur_q];

    // In the first IDLE cycle after a load the restored state comes straight from the RAM.
    assign growth_live = first_idle_q ? ram_rdata[RAM_W-1:1] : growth_q;
    assign error_live  = first_idle_q ? ram_rdata[0] : error_q;

    always_comb begin
        sum = '0;
        unique case (bc)
            BC_BOUNDARY: sum = SUM_W'(growth_live) + SUM_W'(a_increase);
            BC_ABSENT:   sum = '0;
            default:     sum = SUM_W'(growth_live) + SUM_W'(a_increase) + SUM_W'(b_increase);
        endcase
        grown = (sum >= SUM_W'(weight)) ? weight : sum[LINK_BIT_WIDTH-1:0];
    end

    always_comb begin
        error_next = 1'b0;
        if (bc == BC_ABSENT) begin
            error_next = 1'b0;
        end else if (global_stage == STAGE_RESULT_VALID) begin
            error_next = is_error_systolic_in;
        end else if (bc == BC_BOUNDARY) begin
            error_next = a_is_error_in;
        end else begin
            error_next = a_is_error_in | b_is_error_in;
        end
    end

    always_comb begin
        state_d   = state_q;
        growth_d  = growth_q;
        error_d   = error_q;
        ctx_cur_d = ctx_cur_q;
        unique case (state_q)
            CTX_CLEAR: begin
                if (clear_idx_q == CTX_W'(NUM_CONTEXTS - 1)) begin
                    growth_d  = '0;
                    error_d   = 1'b0;
                    ctx_cur_d = '0;
                    state_d   = CTX_IDLE;
                end
            end
            CTX_IDLE: begin
                growth_d = reset_edge ? '0 : grown;
                error_d  = error_next;
                if (ctx_clear_all) begin
                    state_d = CTX_CLEAR;
                end else if (ctx_switch_valid) begin
                    state_d = CTX_SAVE;
                end
            end
            CTX_SAVE: state_d = CTX_LOAD;
            CTX_LOAD: begin
                state_d   = CTX_IDLE;
                ctx_cur_d = ctx_next_q;
            end
            default: state_d = CTX_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= CTX_CLEAR;
            growth_q     <= '0;
            error_q      <= 1'b0;
            ctx_cur_q    <= '0;
            ctx_next_q   <= '0;
            clear_idx_q  <= '0;
            first_idle_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            growth_q     <= growth_d;
            error_q      <= error_d;
            ctx_cur_q    <= ctx_cur_d;
            first_idle_q <= (state_q == CTX_LOAD);
            if (state_q == CTX_IDLE && ctx_switch_valid && !ctx_clear_all) begin
                ctx_next_q <= ctx_next;
            end
            if (state_q == CTX_CLEAR && clear_idx_q != CTX_W'(NUM_CONTEXTS - 1)) begin
                clear_idx_q <= clear_idx_q + CTX_W'(1);
            end else begin
                clear_idx_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CONTEXTS; i++) begin
                cfg_weight_q[i] <= '0;
                cfg_bc_q[i]     <= '0;
            end
        end else if (cfg_we) begin
            cfg_weight_q[cfg_ctx] <= weight_in;
            cfg_bc_q[cfg_ctx]     <= boundary_condition_in;
        end
    end

    always_comb begin
        ram_we    = (state_q == CTX_CLEAR) || (state_q == CTX_SAVE);
        ram_wdata = (state_q == CTX_SAVE) ? {growth_q, error_q} : '0;
        unique case (state_q)
            CTX_CLEAR: ram_addr = clear_idx_q;
            CTX_SAVE:  ram_addr = ctx_cur_q;
            default:   ram_addr = ctx_next_q;
        endcase
    end

    link_ctx_ram #(
        .DEPTH  (NUM_CONTEXTS),
        .WIDTH  (RAM_W),
        .ADDR_W (CTX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign fully_grown      = (growth_live >= weight) && (bc != BC_ABSENT);
    assign is_boundary      = fully_grown && (bc == BC_BOUNDARY || bc == BC_FUSION);
    assign is_error         = error_live;
    assign a_output_data    = (bc == BC_NONE) ? b_input_data : '0;
    assign b_output_data    = (bc == BC_NONE) ? a_input_data : '0;
    assign ctx_switch_ready = (state_q == CTX_IDLE);
    assign ctx_current      = ctx_cur_q;

    assert property (@(posedge clk) disable iff (reset)
        (state_q == CTX_IDLE && ctx_switch_valid) |-> (int'(ctx_next) < NUM_CONTEXTS))
        else $error("ctx_next out of range");

endmodule
